// File: rtl/spi_sched_pkg.sv
// Shared encodings and widths for the SPI engine scheduler.
package spi_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_RUN       = 3'd3,
        S_DONE      = 3'd4
    } sched_state_t;

    localparam int SPI_WORD_W = 16;
    localparam int SPI_RX_W   = 8;
    localparam int TMO_W      = 4;

endpackage

// File: rtl/spi_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from pointer+1.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   index,
    output logic               any
);

    int cand;

    always_comb begin
        winner = '0;
        index  = '0;
        any    = 1'b0;
        cand   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(pointer) + k) % NUM_REQ;
            if (!any && req[cand]) begin
                any          = 1'b1;
                winner[cand] = 1'b1;
                index        = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/spi_scheduler.sv
// Shares one SPI engine among NUM_REQ requesters with round-robin arbitration.
// Optional chip-select outputs are built when SPI_SCHED_CS_EN is defined.
module spi_scheduler
    import spi_sched_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int START_TIMEOUT = 15
) (
    input  logic                       raw_clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         req_width_16,
    input  logic [SPI_WORD_W*NUM_REQ-1:0] req_tx,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic                       error,
    output logic [SPI_RX_W-1:0]        rx_data,
    output logic                       spi_start,
    output logic                       spi_width_16,
    output logic [SPI_WORD_W-1:0]      spi_tx,
    input  logic                       spi_busy,
    input  logic [SPI_RX_W-1:0]        spi_rx
`ifdef SPI_SCHED_CS_EN
    ,output logic [NUM_REQ-1:0]        spi_cs_n
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    sched_state_t     state;
    sched_state_t     state_next;
    logic [IDX_W-1:0] rr_ptr;
    logic [TMO_W-1:0] tmo_cnt;
    logic             timeout_hit;

    logic [NUM_REQ-1:0] arb_winner;
    logic [IDX_W-1:0]   arb_index;
    logic               arb_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req     (req),
        .pointer (rr_ptr),
        .winner  (arb_winner),
        .index   (arb_index),
        .any     (arb_any)
    );

    assign timeout_hit = (tmo_cnt == TMO_W'(START_TIMEOUT));

    always_ff @(posedge raw_clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (arb_any) state_next = S_START;
            S_START:     state_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (spi_busy)         state_next = S_RUN;
                else if (timeout_hit) state_next = S_DONE;
            end
            S_RUN:       if (!spi_busy) state_next = S_DONE;
            S_DONE:      state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // Busy is checked before the timeout so a late but valid busy still wins.
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            grant        <= '0;
            done         <= '0;
            error        <= 1'b0;
            rx_data      <= '0;
            spi_start    <= 1'b0;
            spi_width_16 <= 1'b0;
            spi_tx       <= '0;
            tmo_cnt      <= '0;
            rr_ptr       <= IDX_W'(NUM_REQ - 1);
        end else begin
            done <= '0;
            case (state)
                S_IDLE: begin
                    if (arb_any) begin
                        grant        <= arb_winner;
                        spi_tx       <= req_tx[SPI_WORD_W*int'(arb_index) +: SPI_WORD_W];
                        spi_width_16 <= req_width_16[arb_index];
                        rr_ptr       <= arb_index;
                    end
                end
                S_START: begin
                    spi_start <= 1'b1;
                    tmo_cnt   <= '0;
                end
                S_WAIT_BUSY: begin
                    if (spi_busy) begin
                        spi_start <= 1'b0;
                    end else if (timeout_hit) begin
                        spi_start <= 1'b0;
                        error     <= 1'b1;
                        done      <= grant;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!spi_busy) begin
                        rx_data <= spi_rx;
                        error   <= 1'b0;
                        done    <= grant;
                    end
                end
                S_DONE: grant <= '0;
                default: ;
            endcase
        end
    end

`ifdef SPI_SCHED_CS_EN
    // Select drops with the grant and releases after DONE, leaving the IDLE cycle high.
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            spi_cs_n <= '1;
        end else if (state == S_IDLE && arb_any) begin
            spi_cs_n <= ~arb_winner;
        end else if (state == S_DONE) begin
            spi_cs_n <= '1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_scheduler.sv
// Scoreboard bench for spi_scheduler with a behavioural SPI engine model.
module tb_spi_scheduler;
    import spi_sched_pkg::*;

    localparam int NUM_REQ = 2;

    logic        raw_clk;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  req_width_16;
    logic [31:0] req_tx;
    logic [1:0]  grant;
    logic [1:0]  done;
    logic        error;
    logic [7:0]  rx_data;
    logic        spi_start;
    logic        spi_width_16;
    logic [15:0] spi_tx;
    logic        spi_busy;
    logic [7:0]  spi_rx;
`ifdef SPI_SCHED_CS_EN
    logic [1:0]  spi_cs_n;
`endif

    spi_scheduler #(.NUM_REQ(NUM_REQ), .START_TIMEOUT(15)) dut (
        .raw_clk      (raw_clk),
        .reset        (reset),
        .req          (req),
        .req_width_16 (req_width_16),
        .req_tx       (req_tx),
        .grant        (grant),
        .done         (done),
        .error        (error),
        .rx_data      (rx_data),
        .spi_start    (spi_start),
        .spi_width_16 (spi_width_16),
        .spi_tx       (spi_tx),
        .spi_busy     (spi_busy),
        .spi_rx       (spi_rx)
`ifdef SPI_SCHED_CS_EN
        ,.spi_cs_n    (spi_cs_n)
`endif
    );

    initial raw_clk = 1'b0;
    always #5 raw_clk = ~raw_clk;

    int cyc = 0;
    always @(posedge raw_clk) cyc <= cyc + 1;

    // Engine model: busy rises two cycles after start is seen, stays high 16 cycles.
    logic       mdl_dead = 1'b0;
    int         mdl_phase = 0;
    int         mdl_cnt = 0;
    initial begin
        spi_busy = 1'b0;
        spi_rx   = 8'h00;
    end
    always @(posedge raw_clk) begin
        if (mdl_phase == 0) begin
            if (spi_start && !mdl_dead) begin
                mdl_phase <= 1;
                mdl_cnt   <= 1;
            end
        end else if (mdl_phase == 1) begin
            if (mdl_cnt == 0) begin
                spi_busy  <= 1'b1;
                spi_rx    <= ~spi_tx[7:0];
                mdl_phase <= 2;
                mdl_cnt   <= 15;
            end else begin
                mdl_cnt <= mdl_cnt - 1;
            end
        end else begin
            if (mdl_cnt == 0) begin
                spi_busy  <= 1'b0;
                mdl_phase <= 0;
            end else begin
                mdl_cnt <= mdl_cnt - 1;
            end
        end
    end

    typedef struct {
        logic [1:0] done;
        logic       err;
        logic [7:0] rx;
    } exp_t;
    exp_t sb[$];

    int n_vec = 0;
    int n_bad = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge raw_clk) begin
        if (!reset && (done != 2'b00)) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL done_unexpected: got done=%b expected no done", done);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_onehot", 32'(done), 32'(e.done));
                check("done_error", 32'(error), 32'(e.err));
                if (!e.err) check("rx_data", 32'(rx_data), 32'(e.rx));
            end
        end
    end

    task automatic tick();
        @(posedge raw_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 2'b00;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_grant(input string name);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (grant != 2'b00) return;
        end
        check({name, "_grant_timeout"}, 32'(grant), 32'h1);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done != 2'b00) return;
        end
        check({name, "_done_timeout"}, 32'(done), 32'h1);
    endtask

    function automatic void push(logic [1:0] d, logic err, logic [7:0] rx);
        exp_t e;
        e.done = d;
        e.err  = err;
        e.rx   = rx;
        sb.push_back(e);
    endfunction

    int g_cyc;

    initial begin
        reset        = 1'b1;
        req          = 2'b00;
        req_width_16 = 2'b00;
        req_tx       = 32'h0;
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        check("rst_rx", 32'(rx_data), 32'h0);
        check("rst_start", 32'(spi_start), 32'h0);
        check("rst_tx", 32'(spi_tx), 32'h0);
`ifdef SPI_SCHED_CS_EN
        check("rst_cs_n", 32'(spi_cs_n), 32'h3);
`endif
        reset = 1'b0;

        // 1: single transfer from requester 0
        req_tx = 32'h0000_00A5;
        req_width_16 = 2'b00;
        req = 2'b01;
        push(2'b01, 1'b0, 8'h5A);
        tick();
        g_cyc = cyc;
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_tx", 32'(spi_tx), 32'h00A5);
        check("t1_width", 32'(spi_width_16), 32'h0);
        check("t1_start_lat0", 32'(spi_start), 32'h0);
        tick();
        check("t1_start_lat1", 32'(spi_start), 32'h1);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (spi_busy) break;
            check("t1_start_hold", 32'(spi_start), 32'h1);
        end
        tick();
        check("t1_start_drop", 32'(spi_start), 32'h0);
        wait_done("t1");
        check("t1_latency", 32'(cyc - g_cyc), 32'd21);
        req = 2'b00;
        tick();
        tick();
        check("t1_grant_clear", 32'(grant), 32'h0);

        // 2: both requesting, strict rotation from reset
        do_reset();
        req_tx = {16'hABCD, 16'h1234};
        req_width_16 = 2'b01;
        req = 2'b11;
        push(2'b01, 1'b0, 8'hCB);
        push(2'b10, 1'b0, 8'h32);
        push(2'b01, 1'b0, 8'hCB);
        push(2'b10, 1'b0, 8'h32);
        for (int t = 0; t < 4; t++) begin
            wait_grant("t2");
            check("t2_grant", 32'(grant), (t % 2 == 0) ? 32'h1 : 32'h2);
            check("t2_tx", 32'(spi_tx), (t % 2 == 0) ? 32'h1234 : 32'hABCD);
            check("t2_width", 32'(spi_width_16), (t % 2 == 0) ? 32'h1 : 32'h0);
            wait_done("t2");
        end
        req = 2'b00;

        // 3: engine never responds, start times out
        mdl_dead = 1'b1;
        req_tx = 32'h0000_00FF;
        req = 2'b01;
        push(2'b01, 1'b1, 8'h00);
        wait_grant("t3");
        g_cyc = cyc;
        check("t3_grant", 32'(grant), 32'h1);
        wait_done("t3");
        check("t3_abort_cycles", 32'(cyc - g_cyc), 32'd17);
        check("t3_error", 32'(error), 32'h1);
        check("t3_start_low", 32'(spi_start), 32'h0);
        req = 2'b00;
        mdl_dead = 1'b0;
        tick();

        // 4: requester 1 drops req right after grant; requester 0 queued behind
        req_tx = 32'h5AC3_0011;
        req_width_16 = 2'b10;
        req = 2'b10;
        push(2'b10, 1'b0, 8'h3C);
        push(2'b01, 1'b0, 8'hEE);
        wait_grant("t4");
        check("t4_grant1", 32'(grant), 32'h2);
        req = 2'b01;
        req_tx[31:16] = 16'hFFFF;
        tick();
        check("t4_tx_hold", 32'(spi_tx), 32'h5AC3);
        check("t4_width_hold", 32'(spi_width_16), 32'h1);
        wait_done("t4");
        check("t4_error_clear", 32'(error), 32'h0);
        wait_grant("t4b");
        check("t4_grant0", 32'(grant), 32'h1);
        wait_done("t4b");
        req = 2'b00;

        // 5: reset during RUN
        req_tx = 32'h0F0F_0001;
        req = 2'b10;
        wait_grant("t5");
        check("t5_grant1", 32'(grant), 32'h2);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (spi_busy) break;
        end
        tick();
        check("t5_in_run", 32'(dut.state), 32'(S_RUN));
        reset = 1'b1;
        req = 2'b00;
        tick();
        check("t5_state_idle", 32'(dut.state), 32'(S_IDLE));
        check("t5_grant_zero", 32'(grant), 32'h0);
        check("t5_start_zero", 32'(spi_start), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!spi_busy) break;
            tick();
        end
        req = 2'b11;
        push(2'b01, 1'b0, 8'hFE);
        wait_grant("t5b");
        check("t5_grant0", 32'(grant), 32'h1);
        wait_done("t5b");
        req = 2'b00;

`ifdef SPI_SCHED_CS_EN
        // 6: chip-select framing on back-to-back transfers
        do_reset();
        req_tx = 32'h8001_0000;
        req = 2'b11;
        push(2'b01, 1'b0, 8'hFF);
        push(2'b10, 1'b0, 8'hFE);
        wait_grant("t6");
        check("t6_cs_first", 32'(spi_cs_n), 32'h2);
        wait_done("t6");
        tick();
        check("t6_cs_gap", 32'(spi_cs_n), 32'h3);
        tick();
        check("t6_grant1", 32'(grant), 32'h2);
        begin
            int low_cnt = 0;
            for (int i = 0; i < 60; i++) begin
                if (spi_cs_n[1] == 1'b0) low_cnt++;
                if (done != 2'b00) break;
                tick();
            end
            req = 2'b00;
            check("t6_cs_low_cycles", 32'(low_cnt), 32'd22);
        end
        tick();
        check("t6_cs_release", 32'(spi_cs_n), 32'h3);
`endif

        repeat (4) tick();
        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
